handle_servo_pwm: RTL and testbench

- Downstream consumer of the myip_handle AXI4-Lite register file. Takes four per-channel handle target positions (pulse widths in µs) from slv_reg0..3 write strobes.
- Slew-limits each channel toward its target once per servo frame.
- Generates four servo PWM outputs that drive the digger's boom/arm/bucket/swing actuators.
- Exposes current positions and settled flags for register readback.

---
 rtl/handle_pkg.sv | 37 +++
 rtl/handle_slew_ch.sv | 47 ++++
 rtl/handle_servo_pwm.sv | 79 +++++++
 tb/tb_handle_servo_pwm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/handle_pkg.sv
// Shared types and arithmetic helpers for the handle servo PWM block.
package handle_pkg;

  localparam int NUM_CH = 4;

  typedef logic [15:0] pos_t;

  function automatic pos_t clamp_pos(input pos_t v, input pos_t lo, input pos_t hi);
    pos_t r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Difference is only taken after the compare, so it can never wrap.
  function automatic pos_t slew_step(input pos_t cur, input pos_t tgt, input pos_t step);
    pos_t d;
    pos_t r;
    if (cur < tgt) begin
      d = tgt - cur;
      r = cur + ((d < step) ? d : step);
    end else if (cur > tgt) begin
      d = cur - tgt;
      r = cur - ((d < step) ? d : step);
    end else begin
      d = 16'd0;
      r = cur;
    end
    return r;
  endfunction

endpackage

// File: rtl/handle_slew_ch.sv
// One servo channel: clamped target capture, per-frame slew and PWM compare.
module handle_slew_ch
  import handle_pkg::*;
#(
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500,
  parameter int STEP_US   = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_tgt_wr,
  input  pos_t i_tgt_data,
  input  logic i_frame_start,
  input  pos_t i_us_cnt,
  output logic o_pwm,
  output pos_t o_cur_pos,
  output logic o_settled
);

  pos_t r_tgt;
  pos_t r_cur;
  logic r_pwm;

  // Slew reads the pre-write target, so a write landing on frame_start waits a frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tgt <= pos_t'(CENTER_US);
      r_cur <= pos_t'(CENTER_US);
      r_pwm <= 1'b0;
    end else begin
      if (i_tgt_wr) begin
        r_tgt <= clamp_pos(i_tgt_data, pos_t'(MIN_US), pos_t'(MAX_US));
      end
      if (i_frame_start) begin
        r_cur <= slew_step(r_cur, r_tgt, pos_t'(STEP_US));
      end
      r_pwm <= i_enable && (i_us_cnt < r_cur);
    end
  end

  assign o_pwm     = r_pwm;
  assign o_cur_pos = r_cur;
  assign o_settled = (r_cur == r_tgt);

endmodule

// File: rtl/handle_servo_pwm.sv
// Four-channel slew-limited servo PWM generator fed by register-file target writes.
module handle_servo_pwm
  import handle_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500,
  parameter int STEP_US   = 10
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   tgt_wr,
  input  logic [16*NUM_CH-1:0] tgt_data,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic [16*NUM_CH-1:0] cur_pos,
  output logic [NUM_CH-1:0]   settled,
  output logic                frame_start
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] r_pre_cnt;
  pos_t             r_us_cnt;
  logic             r_en_d;
  logic             r_frame_start;
  logic             w_tick;
  logic             w_wrap;

  assign w_tick = enable && (r_pre_cnt == PRE_W'(TICK_DIV - 1));
  assign w_wrap = w_tick && (r_us_cnt == pos_t'(PERIOD_US - 1));

  // Prescaler, microsecond frame counter and frame boundary pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pre_cnt     <= '0;
      r_us_cnt      <= 16'd0;
      r_en_d        <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!enable) begin
      r_pre_cnt     <= '0;
      r_us_cnt      <= 16'd0;
      r_en_d        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) begin
        r_us_cnt <= w_wrap ? 16'd0 : r_us_cnt + 16'd1;
      end
      r_en_d        <= 1'b1;
      r_frame_start <= !r_en_d || w_wrap;
    end
  end

  assign frame_start = r_frame_start;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    handle_slew_ch #(
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .CENTER_US(CENTER_US),
      .STEP_US  (STEP_US)
    ) u_ch (
      .i_clk        (ACLK),
      .i_rst        (ARESET),
      .i_enable     (enable),
      .i_tgt_wr     (tgt_wr[i]),
      .i_tgt_data   (tgt_data[16*i +: 16]),
      .i_frame_start(r_frame_start),
      .i_us_cnt     (r_us_cnt),
      .o_pwm        (pwm_out[i]),
      .o_cur_pos    (cur_pos[16*i +: 16]),
      .o_settled    (settled[i])
    );
  end

endmodule

// File: tb/tb_handle_servo_pwm.sv
// Directed bench for handle_servo_pwm with a scaled-down frame (200 ACLK cycles).
module tb_handle_servo_pwm;

  logic        ACLK;
  logic        ARESET;
  logic        enable;
  logic [3:0]  tgt_wr;
  logic [63:0] tgt_data;
  logic [3:0]  pwm_out;
  logic [63:0] cur_pos;
  logic [3:0]  settled;
  logic        frame_start;

  int n_vec  = 0;
  int n_miss = 0;

  handle_servo_pwm #(
    .TICK_DIV (2),
    .PERIOD_US(100),
    .MIN_US   (10),
    .MAX_US   (50),
    .CENTER_US(30),
    .STEP_US  (4)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .enable     (enable),
    .tgt_wr     (tgt_wr),
    .tgt_data   (tgt_data),
    .pwm_out    (pwm_out),
    .cur_pos    (cur_pos),
    .settled    (settled),
    .frame_start(frame_start)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Leaves the bench sampling inside a frame_start cycle, bounded by a cycle budget.
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      step(1);
      n++;
    end
    check_vec(tag, frame_start, 1);
  endtask

  task automatic write_tgt(input logic [3:0] wr, input logic [63:0] data);
    tgt_wr   = wr;
    tgt_data = data;
    step(1);
    tgt_wr   = 4'd0;
    tgt_data = 64'd0;
  endtask

  initial begin
    int cnt [4];
    int fs_cnt;
    logic bad;
    int exp0 [4]   = '{34, 38, 42, 42};
    logic exps [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int exp1 [5]   = '{26, 22, 18, 14, 10};
    int exp2 [5]   = '{34, 38, 42, 46, 50};

    ARESET   = 1'b1;
    enable   = 1'b0;
    tgt_wr   = 4'd0;
    tgt_data = 64'd0;
    step(3);
    check_vec("rst_pwm", pwm_out, 4'h0);
    check_vec("rst_pos", cur_pos, {4{16'd30}});
    check_vec("rst_settled", settled, 4'hF);
    check_vec("rst_fs", frame_start, 1'b0);
    ARESET = 1'b0;
    step(2);

    // 1: idle run at center, 30 us = 60 cycles high per frame
    enable = 1'b1;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    fs_cnt = 0;
    for (int s = 0; s < 200; s++) begin
      step(1);
      for (int c = 0; c < 4; c++) cnt[c] += int'(pwm_out[c]);
      fs_cnt += int'(frame_start);
    end
    for (int c = 0; c < 4; c++) check_vec($sformatf("t1_width%0d", c), cnt[c], 60);
    check_vec("t1_fs_count", fs_cnt, 2);
    check_vec("t1_settled", settled, 4'hF);
    check_vec("t1_pos", cur_pos, {4{16'd30}});

    // 2: ch0 toward 42 in steps of 4
    step(1);
    write_tgt(4'b0001, {48'd0, 16'd42});
    check_vec("t2_unsettled", settled, 4'b1110);
    for (int k = 0; k < 4; k++) begin
      wait_fs($sformatf("t2_fs%0d", k));
      step(1);
      check_vec($sformatf("t2_pos0_%0d", k), cur_pos[15:0], exp0[k]);
      check_vec($sformatf("t2_set0_%0d", k), settled[0], exps[k]);
      check_vec($sformatf("t2_pos3_%0d", k), cur_pos[63:48], 16'd30);
    end

    // 3: out-of-range targets saturate to 10 and 50
    write_tgt(4'b0110, {16'd0, 16'd200, 16'd5, 16'd0});
    check_vec("t3_unsettled", settled, 4'b1001);
    for (int k = 0; k < 5; k++) begin
      wait_fs($sformatf("t3_fs%0d", k));
      step(1);
      check_vec($sformatf("t3_pos1_%0d", k), cur_pos[31:16], exp1[k]);
      check_vec($sformatf("t3_pos2_%0d", k), cur_pos[47:32], exp2[k]);
    end
    check_vec("t3_settled", settled, 4'hF);

    // 4: write landing on the frame_start cycle waits one frame
    wait_fs("t4_fs0");
    write_tgt(4'b1000, {16'd40, 48'd0});
    check_vec("t4_hold", cur_pos[63:48], 16'd30);
    check_vec("t4_unsettled", settled[3], 1'b0);
    wait_fs("t4_fs1");
    step(1);
    check_vec("t4_move", cur_pos[63:48], 16'd34);

    // 5: disable mid-pulse, retarget, re-enable
    step(10);
    check_vec("t5_pulse", pwm_out, 4'hF);
    enable = 1'b0;
    step(1);
    check_vec("t5_pwm_off", pwm_out, 4'h0);
    write_tgt(4'b0001, {48'd0, 16'd20});
    bad = 1'b0;
    for (int s = 0; s < 50; s++) begin
      step(1);
      if (pwm_out != 4'h0 || frame_start != 1'b0) bad = 1'b1;
    end
    check_vec("t5_quiet", bad, 1'b0);
    check_vec("t5_frozen", cur_pos, {16'd34, 16'd50, 16'd10, 16'd42});
    enable = 1'b1;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int s = 0; s < 40; s++) begin
      step(1);
      if (s == 0) check_vec("t5_fs", frame_start, 1'b1);
      for (int c = 0; c < 4; c++) cnt[c] += int'(pwm_out[c]);
    end
    check_vec("t5_width1", cnt[1], 20);
    check_vec("t5_resume", cur_pos, {16'd38, 16'd50, 16'd10, 16'd38});

    // 6: asynchronous reset mid-frame, no clock edge in between
    check_vec("t6_pre", cur_pos[15:0], 16'd38);
    #1 ARESET = 1'b1;
    #2;
    check_vec("t6_pwm", pwm_out, 4'h0);
    check_vec("t6_pos0", cur_pos[15:0], 16'd30);
    check_vec("t6_pos", cur_pos, {4{16'd30}});
    check_vec("t6_settled", settled, 4'hF);
    check_vec("t6_fs", frame_start, 1'b0);
    ARESET = 1'b0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int s = 0; s < 200; s++) begin
      step(1);
      if (s == 0) check_vec("t6_restart_fs", frame_start, 1'b1);
      for (int c = 0; c < 4; c++) cnt[c] += int'(pwm_out[c]);
    end
    check_vec("t6_width0", cnt[0], 60);
    check_vec("t6_width3", cnt[3], 60);
    check_vec("t6_final", cur_pos, {4{16'd30}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
